dmem_store_buffer: RTL and testbench

- Data-memory stage that sits directly downstream of the pipelined core's Memory stage.
- Consumes ALUOutM, WriteDataM and MemWriteM, and returns ReadDataM combinationally in the same cycle.
- Stores enter a small FIFO store buffer and drain lazily into an internal word RAM.
- Loads forward from the youngest matching buffered store, so the core never stalls on memory.

---
 rtl/dmem_store_buffer.sv | 115 +++++++++++
 tb/tb_dmem_store_buffer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: data-memory stage with a FIFO store buffer, lazy drain and store-to-load forwarding.
// Optional macro STBUF_COALESCE_EN merges a store into an existing buffered entry with the same word index.
module dmem_store_buffer #(
    parameter int DEPTH     = 4,
    parameter int MEM_WORDS = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              ALUOutM,
    input  logic [31:0]              WriteDataM,
    input  logic                     MemWriteM,
    output logic [31:0]              ReadDataM,
    output logic                     sb_empty,
    output logic [$clog2(DEPTH):0]   sb_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int IW = $clog2(MEM_WORDS);

    logic [DEPTH-1:0] valid;
    logic [IW-1:0]    idxArr  [DEPTH];
    logic [31:0]      dataArr [DEPTH];
    logic [31:0]      ram     [MEM_WORDS];
    logic [PW-1:0]    head, tail;
    logic [PW:0]      count, countNext;
    logic [IW-1:0]    wIdx;
    logic [DEPTH-1:0] hitVec;
    logic             full, drain, enq, coalesce;

    assign wIdx = ALUOutM[IW+1:2];

    always_comb begin
        hitVec = '0;
        for (int i = 0; i < DEPTH; i++) hitVec[i] = valid[i] && (idxArr[i] == wIdx);
    end

    assign full      = count == (PW+1)'(DEPTH);
    assign drain     = (count != '0) && (!MemWriteM || full);
    assign enq       = MemWriteM && !coalesce;
    assign countNext = count + {{PW{1'b0}}, enq} - {{PW{1'b0}}, drain};
    assign sb_count  = count;

`ifdef STBUF_COALESCE_EN
    logic [PW-1:0] hitPos;
    logic [31:0]   fwdData;

    always_comb begin
        hitPos = '0;
        for (int i = 0; i < DEPTH; i++) if (hitVec[i]) hitPos = PW'(i);
    end

    // A hit on the head that is leaving this edge cannot absorb the store.
    assign coalesce = MemWriteM && (|hitVec) && !(drain && hitPos == head);

    always_comb begin
        fwdData = '0;
        for (int i = 0; i < DEPTH; i++) fwdData = fwdData | (dataArr[i] & {32{hitVec[i]}});
        ReadDataM = (|hitVec) ? fwdData : ram[wIdx];
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            idxArr[tail]  <= wIdx;
            dataArr[tail] <= WriteDataM;
        end
        if (coalesce) dataArr[hitPos] <= WriteDataM;
    end
`else
    logic [PW-1:0] fwdPos;

    assign coalesce = 1'b0;

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwdPos    = head;
        ReadDataM = ram[wIdx];
        for (int i = 0; i < DEPTH; i++) begin
            fwdPos = head + PW'(i);
            if (hitVec[fwdPos]) ReadDataM = dataArr[fwdPos];
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            idxArr[tail]  <= wIdx;
            dataArr[tail] <= WriteDataM;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid    <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            sb_empty <= 1'b1;
        end else begin
            if (drain) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            if (enq) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            count    <= countNext;
            sb_empty <= countNext == '0;
        end
    end

    // Gated by reset so a drain never lands in RAM while reset is held.
    always_ff @(posedge clk) begin
        if (reset && drain) ram[idxArr[head]] <= dataArr[head];
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: scoreboard bench for dmem_store_buffer against a queue-based reference model.
module tb_dmem_store_buffer;
    localparam int DEPTH = 4;
    localparam int MW    = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [31:0] ALUOutM = '0;
    logic [31:0] WriteDataM = '0;
    logic [31:0] ReadDataM;
    logic        sb_empty;
    logic [$clog2(DEPTH):0] sb_count;

    dmem_store_buffer #(.DEPTH(DEPTH), .MEM_WORDS(MW)) dut (
        .clk(clk), .reset(reset), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .MemWriteM(MemWriteM), .ReadDataM(ReadDataM), .sb_empty(sb_empty), .sb_count(sb_count)
    );

    always #5 clk = ~clk;

    typedef struct {logic [5:0] i; logic [31:0] d;} ent_t;
    ent_t        mq[$];
    logic [31:0] mmem [MW];
    bit          mknown [MW];
    logic [31:0] sbq[$];
    logic [31:0] lastRd;
    int tests = 0, errs = 0, peak = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mfwd(logic [5:0] i, output bit known);
        logic [31:0] v;
        known = mknown[i];
        v = mmem[i];
        foreach (mq[k]) if (mq[k].i == i) begin v = mq[k].d; known = 1'b1; end
        return v;
    endfunction

    task automatic cyc(bit we, logic [31:0] a, logic [31:0] d);
        bit kn, dr, coal;
        logic [5:0] wi;
        ent_t e;
        int k;
        wi = a[7:2];
        @(negedge clk);
        check("sb_count", 32'(sb_count), 32'(mq.size()));
        check("sb_empty", 32'(sb_empty), 32'(mq.size() == 0));
        if (int'(sb_count) > peak) peak = int'(sb_count);
        MemWriteM = we; ALUOutM = a; WriteDataM = d;
        sbq.push_back(mfwd(wi, kn));
        #2;
        lastRd = ReadDataM;
        if (kn) check("ReadDataM", ReadDataM, sbq.pop_front());
        else void'(sbq.pop_front());
        dr = mq.size() > 0 && (!we || mq.size() == DEPTH);
        coal = 1'b0;
        k = -1;
`ifdef STBUF_COALESCE_EN
        foreach (mq[j]) if (mq[j].i == wi) k = j;
        coal = we && k >= 0 && !(dr && k == 0);
        if (coal) mq[k].d = d;
`endif
        if (dr) begin e = mq.pop_front(); mmem[e.i] = e.d; mknown[e.i] = 1'b1; end
        if (we && !coal) mq.push_back('{wi, d});
    endtask

    task automatic ld(logic [31:0] a, logic [31:0] expc, string tag);
        cyc(1'b0, a, 32'h0);
        check(tag, lastRd, expc);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(sb_count), 32'd0);
        check("rst_empty", 32'(sb_empty), 32'd1);
        @(negedge clk) reset = 1'b1;

        cyc(1'b1, 32'h14, 32'hDEADBEEF);
        cyc(1'b0, 32'h0, 32'h0);
        ld(32'h14, 32'hDEADBEEF, "idle_read");
        check("idle_empty", 32'(sb_empty), 32'd1);

        cyc(1'b1, 32'h20, 32'h11112222);
        ld(32'h20, 32'h11112222, "fwd_read");
        ld(32'h20, 32'h11112222, "fwd_ram");

        for (int i = 0; i < 5; i++) cyc(1'b1, 32'(i * 4), 32'(i + 1));
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h14, 32'h0);
        for (int i = 0; i < 5; i++) ld(32'(i * 4), 32'(i + 1), "full_ram");

        peak = 0;
        cyc(1'b1, 32'h40, 32'hA);
        cyc(1'b1, 32'h40, 32'hB);
        ld(32'h40, 32'hB, "young_fwd");
`ifdef STBUF_COALESCE_EN
        check("young_peak", 32'(peak), 32'd1);
`else
        check("young_peak", 32'(peak), 32'd2);
`endif
        cyc(1'b0, 32'h0, 32'h0);
        cyc(1'b0, 32'h0, 32'h0);
        ld(32'h40, 32'hB, "young_ram");

        cyc(1'b1, 32'h140, 32'hC0FFEE);
        ld(32'h40, 32'hC0FFEE, "alias_fwd");
        ld(32'h240, 32'hC0FFEE, "alias_ram");

        for (int i = 0; i < 150; i++)
            cyc(1'($urandom_range(0, 1)),
                32'((32 + $urandom_range(0, 7)) * 4) | (32'($urandom_range(0, 3)) << 8),
                $urandom);
        for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 32'h80, 32'h0);

        cyc(1'b1, 32'h00, 32'd7);
        cyc(1'b1, 32'h04, 32'd8);
        cyc(1'b1, 32'h08, 32'd9);
        @(negedge clk);
        MemWriteM = 1'b0;
        check("pre_rst_count", 32'(sb_count), 32'd3);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_count", 32'(sb_count), 32'd0);
        check("mid_rst_empty", 32'(sb_empty), 32'd1);
        #1 reset = 1'b1;
        mq.delete();
        for (int i = 0; i < 3; i++) ld(32'(i * 4), 32'(i + 1), "rst_ram");

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
